// File: rtl/mem_responder.sv
// Word-addressed memory slave with a req/ready handshake, configurable wait
// states, and error flagging for misaligned or out-of-range accesses.
module mem_responder #(
  parameter int DEPTH       = 64,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        we,
  input  logic [31:0] adr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ready,
  output logic        err,
  output logic        busy
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t      state, state_n;
  logic [3:0]  cnt, cnt_n;
  logic [31:0] adr_q, wdata_q;
  logic        we_q;
  logic [31:0] mem [DEPTH];

  logic [31:0] eff_adr;
  logic        eff_we;
  logic        bad;
  logic        to_resp;

  // A zero-wait request enters RESP straight from IDLE, before adr/we are
  // latched, so the response flops must look at the live inputs in that case.
  assign eff_adr = (state == IDLE) ? adr : adr_q;
  assign eff_we  = (state == IDLE) ? we  : we_q;
  assign bad     = (eff_adr[1:0] != 2'b00) || (eff_adr >= 32'(DEPTH * 4));
  assign to_resp = (state_n == RESP);
  assign busy    = (state != IDLE);

  always_comb begin
    // NOTE: every output of this block gets a default first so no path
    // leaves a variable unassigned, which would infer a latch.
    state_n = state;
    cnt_n   = cnt;
    unique case (state)
      IDLE: if (req) begin
        cnt_n   = 4'(WAIT_CYCLES);
        state_n = (WAIT_CYCLES == 0) ? RESP : WAIT;
      end
      WAIT: begin
        cnt_n = cnt - 4'd1;
        if (cnt == 4'd1) state_n = RESP;
      end
      RESP:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      cnt     <= '0;
      adr_q   <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
      ready   <= 1'b0;
      err     <= 1'b0;
      rdata   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      if (state == IDLE && req) begin
        adr_q   <= adr;
        we_q    <= we;
        wdata_q <= wdata;
      end
      ready <= to_resp;
      err   <= to_resp && bad;
      if (to_resp && !eff_we)
        rdata <= bad ? 32'd0 : mem[eff_adr[AW+1:2]];
    end
  end

  // NOTE: the array has no reset; its contents are undefined after power-up
  // and must survive a reset pulse. A reset during RESP forces IDLE, which
  // suppresses the write.
  always_ff @(posedge clk) begin
    if (state == RESP && we_q && !err)
      mem[adr_q[AW+1:2]] <= wdata_q;
  end

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: three instances (WAIT_CYCLES 0, 1, 2) checked
// against a word-array model with directed and randomized transactions.
module tb_mem_responder;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req_s   [3];
  logic        we_s    [3];
  logic [31:0] adr_s   [3];
  logic [31:0] wdata_s [3];
  logic [31:0] rdata_s [3];
  logic        ready_s [3];
  logic        err_s   [3];
  logic        busy_s  [3];

  int vectors    = 0;
  int miscompares = 0;

  logic [31:0] model   [3][64];
  logic [31:0] last_rd [3];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    mem_responder #(.DEPTH(64), .WAIT_CYCLES(g)) u_dut (
      .clk   (clk),
      .reset (reset),
      .req   (req_s[g]),
      .we    (we_s[g]),
      .adr   (adr_s[g]),
      .wdata (wdata_s[g]),
      .rdata (rdata_s[g]),
      .ready (ready_s[g]),
      .err   (err_s[g]),
      .busy  (busy_s[g])
    );
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_all_reset(input string tag);
    for (int k = 0; k < 3; k++) begin
      check({tag, "_ready"}, 32'(ready_s[k]), 32'd0);
      check({tag, "_err"},   32'(err_s[k]),   32'd0);
      check({tag, "_busy"},  32'(busy_s[k]),  32'd0);
      check({tag, "_rdata"}, rdata_s[k],      32'd0);
    end
  endtask

  // One complete transaction on instance k; entered and left at a negedge
  // with the instance idle.
  task automatic txn(input int k, input logic w, input logic [31:0] a, input logic [31:0] d);
    logic        bad;
    logic [31:0] exp_rd;
    int          lat;
    bad = (a[1:0] != 2'b00) || (a >= 32'd256);
    if (w) exp_rd = last_rd[k];
    else   exp_rd = bad ? 32'd0 : model[k][a[7:2]];
    req_s[k] = 1'b1; we_s[k] = w; adr_s[k] = a; wdata_s[k] = d;
    @(posedge clk);
    @(negedge clk);
    req_s[k] = 1'b0; we_s[k] = 1'($urandom); adr_s[k] = $urandom; wdata_s[k] = $urandom;
    lat = 0;
    while (ready_s[k] !== 1'b1 && lat < 20) begin
      check("busy_wait", 32'(busy_s[k]), 32'd1);
      @(negedge clk);
      lat++;
    end
    check("latency", 32'(lat), 32'(k));
    check("busy_resp", 32'(busy_s[k]), 32'd1);
    check("err", 32'(err_s[k]), 32'(bad));
    check("rdata", rdata_s[k], exp_rd);
    @(negedge clk);
    check("ready_pulse", 32'(ready_s[k]), 32'd0);
    check("err_pulse", 32'(err_s[k]), 32'd0);
    check("busy_idle", 32'(busy_s[k]), 32'd0);
    check("rdata_hold", rdata_s[k], exp_rd);
    if (w && !bad) model[k][a[7:2]] = d;
    last_rd[k] = exp_rd;
  endtask

  initial begin
    logic [31:0] a;
    int          k;
    int          sel;
    for (int i = 0; i < 3; i++) begin
      req_s[i] = 1'b0; we_s[i] = 1'b0; adr_s[i] = '0; wdata_s[i] = '0; last_rd[i] = '0;
    end

    #2;
    check_all_reset("por");
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    // Give every word a known value so later loads have defined expectations.
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 64; j++)
        txn(i, 1'b1, 32'(j * 4), $urandom);

    // Store/load, misaligned and out-of-range with two wait states.
    txn(2, 1'b1, 32'h10,  32'hDEADBEEF);
    txn(2, 1'b0, 32'h10,  32'h0);
    txn(2, 1'b1, 32'h12,  32'h55555555);
    txn(2, 1'b0, 32'h10,  32'h0);
    txn(2, 1'b0, 32'h100, 32'h0);
    txn(2, 1'b0, 32'hFC,  32'h0);

    // req held high with one wait state: accepts every third cycle.
    txn(1, 1'b1, 32'h8, 32'h0BADF00D);
    req_s[1] = 1'b1; we_s[1] = 1'b0; adr_s[1] = 32'h8;
    for (int c = 0; c < 9; c++) begin
      check("hold_busy",  32'(busy_s[1]),  32'((c % 3) != 0));
      check("hold_ready", 32'(ready_s[1]), 32'((c % 3) == 2));
      if (c % 3 == 2) check("hold_rdata", rdata_s[1], 32'h0BADF00D);
      @(negedge clk);
    end
    req_s[1] = 1'b0;
    last_rd[1] = 32'h0BADF00D;
    @(negedge clk);
    check("hold_end_busy", 32'(busy_s[1]), 32'd0);

    // Reset asserted during WAIT aborts the pending store.
    txn(2, 1'b1, 32'h20, 32'hAAAAAAAA);
    req_s[2] = 1'b1; we_s[2] = 1'b1; adr_s[2] = 32'h20; wdata_s[2] = 32'h12345678;
    @(posedge clk);
    @(negedge clk);
    req_s[2] = 1'b0;
    check("pre_rst_busy", 32'(busy_s[2]), 32'd1);
    reset = 1'b0;
    #1;
    check_all_reset("async_rst");
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("rst_no_ready", 32'(ready_s[2]), 32'd0);
    end
    reset = 1'b1;
    for (int i = 0; i < 3; i++) last_rd[i] = '0;
    @(negedge clk);
    txn(2, 1'b0, 32'h20, 32'h0);

    // Zero wait states: response in the cycle right after acceptance.
    txn(0, 1'b1, 32'h4, 32'h0000CAFE);
    txn(0, 1'b0, 32'h4, 32'h0);

    // Randomized traffic across all three instances.
    for (int n = 0; n < 80; n++) begin
      k   = int'($urandom_range(0, 2));
      sel = int'($urandom_range(0, 9));
      if (sel < 7)       a = {24'd0, 6'($urandom_range(0, 63)), 2'b00};
      else if (sel == 7) a = {24'd0, 6'($urandom_range(0, 63)), 2'($urandom_range(1, 3))};
      else if (sel == 8) a = 32'd256 + {$urandom_range(0, 1000), 2'b00};
      else               a = $urandom;
      txn(k, 1'($urandom), a, $urandom);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
